// File: rtl/serial_alu_ctrl_pkg.sv
// Shared constants for the bit-serial ALU sequencer: FSM states and opcode fields.
package serial_alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] OP_AND   = 2'b00;
  localparam logic [1:0] OP_OR    = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_SLT   = 2'b11;
  localparam int         OP_INV_B = 2;

endpackage

// File: rtl/serial_alu_ctrl_slice.sv
// One-bit ALU slice: purely combinational AND/OR/ADD/SLT cell with optional B inversion.
module serial_alu_ctrl_slice
  import serial_alu_ctrl_pkg::*;
(
  input  logic       ai_i,
  input  logic       bi_i,
  input  logic       ci_i,
  input  logic       less_i,
  input  logic [2:0] op_i,
  output logic       ri_o,
  output logic       c_next_o
);

  logic bb, sum;

  assign bb       = bi_i ^ op_i[OP_INV_B];
  assign sum      = ai_i ^ bb ^ ci_i;
  assign c_next_o = (ai_i & bb) | (ai_i & ci_i) | (bb & ci_i);

  always_comb begin
    ri_o = 1'b0;
    unique case (op_i[1:0])
      OP_AND:  ri_o = ai_i & bb;
      OP_OR:   ri_o = ai_i | bb;
      OP_ADD:  ri_o = sum;
      OP_SLT:  ri_o = less_i;
      default: ri_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: one bit per clock, LSB first, through a single ALU slice.
// Optional zero/ovf flag ports are built when SERIAL_ALU_FLAGS_EN is defined.
module serial_alu_ctrl
  import serial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q;
  logic [2:0]       op_q;
  logic             carry_q, cout_q;
  logic [CW-1:0]    cnt_q;

  logic             ri, c_next;
  logic [2:0]       slice_op;
  logic [WIDTH-1:0] res_d, res_fin_d;
  logic             is_slt, is_add;

  assign is_slt = (op_q[1:0] == OP_SLT);
  assign is_add = (op_q[1:0] == OP_ADD);
  // SLT runs the slice as a subtract so the sign of a-b emerges on the last bit.
  assign slice_op  = is_slt ? {1'b1, OP_ADD} : op_q;
  assign res_d     = {ri, res_q[WIDTH-1:1]};
  assign res_fin_d = is_slt ? {{(WIDTH-1){1'b0}}, ri} : res_d;

  serial_alu_ctrl_slice u_slice (
    .ai_i     (a_sh_q[0]),
    .bi_i     (b_sh_q[0]),
    .ci_i     (carry_q),
    .less_i   (1'b0),
    .op_i     (slice_op),
    .ri_o     (ri),
    .c_next_o (c_next)
  );

`ifdef SERIAL_ALU_FLAGS_EN
  logic zero_q, ovf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == RUN && cnt_q == LAST) begin
      zero_q <= (res_fin_d == '0);
      // carry_q here is the carry into the MSB.
      ovf_q  <= is_add & (carry_q ^ c_next);
    end
  end
  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          a_sh_q  <= a;
          b_sh_q  <= b;
          op_q    <= alu_op;
          carry_q <= alu_op[OP_INV_B];
          cnt_q   <= '0;
          res_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          carry_q <= c_next;
          if (cnt_q == LAST) begin
            res_q   <= res_fin_d;
            cout_q  <= is_add & c_next;
            state_q <= DONE;
          end else begin
            res_q <= res_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl: directed test-plan cases plus random ops vs. an arithmetic model.
module tb_serial_alu_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   alu_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout;
`ifdef SERIAL_ALU_FLAGS_EN
  logic         zero, ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout)
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: two's-complement arithmetic on whole words.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [2:0] op,
                                output logic [W-1:0] r, output logic co, output logic z, output logic ov);
    logic [W-1:0] be;
    logic [W:0]   s;
    be = op[2] ? ~mb : mb;
    co = 1'b0;
    ov = 1'b0;
    case (op[1:0])
      2'b00: r = ma & be;
      2'b01: r = ma | be;
      2'b10: begin
        s  = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, op[2]};
        r  = s[W-1:0];
        co = s[W];
        ov = (ma[W-1] == be[W-1]) && (r[W-1] != ma[W-1]);
      end
      default: begin
        s = {1'b0, ma} + {1'b0, ~mb} + {{W{1'b0}}, op[2]};
        r = {{(W-1){1'b0}}, s[W-1]};
      end
    endcase
    z = (r == '0);
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] op,
                        input int hold, input bit poke_run, input string tag);
    logic [W-1:0] er;
    logic ec, ez, eo;
    int n;
    model(ta, tb, op, er, ec, ez, eo);
    @(negedge clk);
    a = ta; b = tb; alu_op = op; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check({tag, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    if (poke_run) begin
      in_valid = 1'b1;
      repeat (4) begin
        @(posedge clk); #1;
        check({tag, "_run_in_ready"}, W'(in_ready), 0);
      end
      in_valid = 1'b0;
      n = 4;
    end else n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    check({tag, "_latency"}, W'(n), W'(W));
    check({tag, "_result"}, result, er);
    check({tag, "_cout"}, W'(cout), W'(ec));
`ifdef SERIAL_ALU_FLAGS_EN
    check({tag, "_zero"}, W'(zero), W'(ez));
    check({tag, "_ovf"}, W'(ovf), W'(eo));
`endif
    repeat (hold) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, W'(out_valid), 1);
      check({tag, "_hold_ready"}, W'(in_ready), 0);
      check({tag, "_hold_result"}, result, er);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check({tag, "_to_idle"}, W'({out_valid, in_ready}), 2'b01);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", W'(in_ready), 1);
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_result", result, 0);
    check("rst_cout", W'(cout), 0);
`ifdef SERIAL_ALU_FLAGS_EN
    check("rst_flags", W'({zero, ovf}), 0);
`endif

    run_op(32'd5, 32'd3, 3'b010, 0, 0, "add_5_3");
    run_op(32'd3, 32'd5, 3'b110, 0, 0, "sub_3_5");
    run_op(32'd5, 32'd3, 3'b110, 0, 0, "sub_5_3");
    run_op(32'hFFFFFFFF, 32'd1, 3'b111, 0, 0, "slt_m1_1");
    run_op(32'd4, 32'd2, 3'b111, 0, 0, "slt_4_2");
    run_op(32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 0, 0, "and");
    run_op(32'hF0F0F0F0, 32'hFF00FF00, 3'b001, 0, 0, "or");
    run_op(32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 0, 0, "andn");
    run_op(32'hF0F0F0F0, 32'hFF00FF00, 3'b101, 0, 0, "orn");
    run_op(32'h12345678, 32'h0000FFFF, 3'b010, 10, 1, "backpressure");
    run_op(32'h7FFFFFFF, 32'd1, 3'b010, 0, 0, "add_ovf");
    run_op(32'd7, 32'd7, 3'b110, 0, 0, "sub_zero");
    run_op(32'h80000000, 32'd1, 3'b110, 0, 0, "sub_ovf");

    // Abort mid-operation with reset at counter == 12.
    @(negedge clk);
    a = 32'hAAAA5555; b = 32'h1234; alu_op = 3'b010; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("abort_out_valid", W'(out_valid), 0);
    check("abort_in_ready", W'(in_ready), 1);
    check("abort_result", result, 0);
    repeat (W + 2) begin
      @(posedge clk); #1;
      check("abort_no_valid", W'(out_valid), 0);
    end
    run_op(32'd1, 32'd1, 3'b010, 0, 0, "post_abort_add");

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = (i % 5 == 0) ? ra : W'($urandom);
      run_op(ra, rb, 3'($urandom_range(0, 7)), $urandom_range(0, 3), 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
